// File: rtl/iic_read8.sv
// I2C master read-byte engine: shifts in eight data bits on SCL high centres,
// drives the ACK/NACK bit, then hands the received byte to the controller.
module iic_read8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       state,
  input  logic       scl_hs,
  input  logic       scl_ls,
  input  logic       scl_lc,
  input  logic       sda_in,
  input  logic       nack,
  output logic       sdar,
  output logic       sdalink,
  output logic [7:0] rd_data,
  output logic       data_valid,
  output logic       next_state_sig
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ACK_WAIT,
    ACK_DRIVE,
    DONE
  } state_t;

  state_t     fsm_q, fsm_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rd_data_d;
  logic       sdar_d, sdalink_d, data_valid_d, next_state_sig_d;

  // Only the highest-priority strobe of a cycle is acted on (ls > hs > lc)
  logic hs_eff, lc_eff;
  assign hs_eff = scl_hs & ~scl_ls;
  assign lc_eff = scl_lc & ~scl_ls & ~scl_hs;

  // Next-state and next-output logic; everything holds unless a step fires
  always_comb begin
    fsm_d            = fsm_q;
    bcnt_d           = bcnt_q;
    shreg_d          = shreg_q;
    rd_data_d        = rd_data;
    sdar_d           = sdar;
    sdalink_d        = sdalink;
    data_valid_d     = 1'b0;
    next_state_sig_d = next_state_sig;

    case (fsm_q)
      IDLE: begin
        bcnt_d    = 4'd0;
        shreg_d   = 8'h00;
        sdalink_d = 1'b0;
        sdar_d    = 1'b0;
        if (state) begin
          fsm_d = RECV;
        end
      end

      RECV: begin
        if (state && hs_eff) begin
          shreg_d = {shreg_q[6:0], sda_in};
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == 4'd7) begin
            fsm_d = ACK_WAIT;
          end
        end
      end

      ACK_WAIT: begin
        if (state && lc_eff) begin
          sdalink_d = 1'b1;
          sdar_d    = nack;
          fsm_d     = ACK_DRIVE;
        end
      end

      ACK_DRIVE: begin
        if (state && scl_ls) begin
          sdalink_d        = 1'b0;
          sdar_d           = 1'b0;
          rd_data_d        = shreg_q;
          data_valid_d     = 1'b1;
          next_state_sig_d = 1'b1;
          fsm_d            = DONE;
        end
      end

      DONE: begin
        sdalink_d        = 1'b0;
        next_state_sig_d = 1'b1;
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State register; en acts as a synchronous clear above all other inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q          <= IDLE;
      bcnt_q         <= 4'd0;
      shreg_q        <= 8'h00;
      rd_data        <= 8'h00;
      sdar           <= 1'b0;
      sdalink        <= 1'b0;
      data_valid     <= 1'b0;
      next_state_sig <= 1'b0;
    end else if (en) begin
      fsm_q          <= IDLE;
      bcnt_q         <= 4'd0;
      shreg_q        <= 8'h00;
      rd_data        <= 8'h00;
      sdar           <= 1'b0;
      sdalink        <= 1'b0;
      data_valid     <= 1'b0;
      next_state_sig <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      bcnt_q         <= bcnt_d;
      shreg_q        <= shreg_d;
      rd_data        <= rd_data_d;
      sdar           <= sdar_d;
      sdalink        <= sdalink_d;
      data_valid     <= data_valid_d;
      next_state_sig <= next_state_sig_d;
    end
  end

endmodule

// File: tb/tb_iic_read8.sv
// Directed bench for iic_read8: table of byte/ACK transactions plus
// hand-written abort, pause and strobe-collision sequences.
module tb_iic_read8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       state;
  logic       scl_hs;
  logic       scl_ls;
  logic       scl_lc;
  logic       sda_in;
  logic       nack;
  logic       sdar;
  logic       sdalink;
  logic [7:0] rd_data;
  logic       data_valid;
  logic       next_state_sig;

  int checks     = 0;
  int errors     = 0;
  int dv_count   = 0;
  int violations = 0;
  logic allow_link = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       nck;
    logic [7:0] exp_rd;
    logic       exp_sdar;
  } vec_t;

  vec_t vecs [5];

  iic_read8 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .state          (state),
    .scl_hs         (scl_hs),
    .scl_ls         (scl_ls),
    .scl_lc         (scl_lc),
    .sda_in         (sda_in),
    .nack           (nack),
    .sdar           (sdar),
    .sdalink        (sdalink),
    .rd_data        (rd_data),
    .data_valid     (data_valid),
    .next_state_sig (next_state_sig)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count data_valid pulses and flag any SDA drive outside the ACK bit
  always @(negedge clk) begin
    if (data_valid) dv_count++;
    if (sdalink && !allow_link) violations++;
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One strobe cycle followed by one quiet cycle; inputs change on negedge
  task automatic pulse(input logic ls, input logic hs, input logic lc);
    scl_ls = ls;
    scl_hs = hs;
    scl_lc = lc;
    @(negedge clk);
    scl_ls = 1'b0;
    scl_hs = 1'b0;
    scl_lc = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    pulse(1'b1, 1'b0, 1'b0);
    sda_in = b;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(v[i]);
  endtask

  // Ninth bit: master drives ACK/NACK, then the falling edge completes the byte
  task automatic apply_stimulus(input logic nck, input logic [7:0] exp_rd,
                                input logic exp_sdar, input logic both);
    nack = nck;
    pulse(1'b1, 1'b0, 1'b0);
    check_output("link_before_ack", {7'd0, sdalink}, 8'h00);
    allow_link = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    check_output("link_ack", {7'd0, sdalink}, 8'h01);
    check_output("sdar_ack", {7'd0, sdar}, {7'd0, exp_sdar});
    if (!both) begin
      pulse(1'b0, 1'b1, 1'b0);
      check_output("link_hold", {7'd0, sdalink}, 8'h01);
      check_output("sdar_hold", {7'd0, sdar}, {7'd0, exp_sdar});
    end
    scl_ls = 1'b1;
    scl_hs = both;
    @(negedge clk);
    scl_ls = 1'b0;
    scl_hs = 1'b0;
    check_output("dv_pulse", {7'd0, data_valid}, 8'h01);
    check_output("rd_data", rd_data, exp_rd);
    check_output("link_release", {7'd0, sdalink}, 8'h00);
    check_output("nss_set", {7'd0, next_state_sig}, 8'h01);
    allow_link = 1'b0;
    @(negedge clk);
    check_output("dv_drop", {7'd0, data_valid}, 8'h00);
    check_output("nss_hold", {7'd0, next_state_sig}, 8'h01);
    pulse(1'b1, 1'b1, 1'b1);
    check_output("dv_count", dv_count[7:0], 8'd1);
    check_output("rd_hold", rd_data, exp_rd);
  endtask

  task automatic pulse_en();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    dv_count = 0;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, nck: 1'b0, exp_rd: 8'hA5, exp_sdar: 1'b0};
    vecs[1] = '{data: 8'h3C, nck: 1'b1, exp_rd: 8'h3C, exp_sdar: 1'b1};
    vecs[2] = '{data: 8'h00, nck: 1'b0, exp_rd: 8'h00, exp_sdar: 1'b0};
    vecs[3] = '{data: 8'hFF, nck: 1'b1, exp_rd: 8'hFF, exp_sdar: 1'b1};
    vecs[4] = '{data: 8'h81, nck: 1'b0, exp_rd: 8'h81, exp_sdar: 1'b0};

    rst_n = 1'b0; en = 1'b0; state = 1'b0; nack = 1'b0; sda_in = 1'b0;
    scl_hs = 1'b0; scl_ls = 1'b0; scl_lc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_rd_data", rd_data, 8'h00);
    check_output("rst_sdalink", {7'd0, sdalink}, 8'h00);
    check_output("rst_sdar", {7'd0, sdar}, 8'h00);
    check_output("rst_dv", {7'd0, data_valid}, 8'h00);
    check_output("rst_nss", {7'd0, next_state_sig}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    state = 1'b1;

    // Table-driven full transactions
    for (int v = 0; v < 5; v++) begin
      pulse_en();
      check_output("en_nss_clear", {7'd0, next_state_sig}, 8'h00);
      check_output("en_rd_clear", rd_data, 8'h00);
      send_bits(vecs[v].data, 7, 0);
      apply_stimulus(vecs[v].nck, vecs[v].exp_rd, vecs[v].exp_sdar, 1'b0);
    end

    // en after four bits of 8'hFF aborts; then 8'h01 received cleanly
    pulse_en();
    send_bits(8'hFF, 7, 4);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_output("abort_rd", rd_data, 8'h00);
    check_output("abort_link", {7'd0, sdalink}, 8'h00);
    check_output("abort_dv", {7'd0, data_valid}, 8'h00);
    check_output("abort_nss", {7'd0, next_state_sig}, 8'h00);
    dv_count = 0;
    send_bits(8'h01, 7, 0);
    apply_stimulus(1'b0, 8'h01, 1'b0, 1'b0);

    // state dropped after three bits of 8'h96 while strobes keep coming
    pulse_en();
    send_bits(8'h96, 7, 5);
    state = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(k[0]);
    @(negedge clk);
    @(negedge clk);
    check_output("pause_link", {7'd0, sdalink}, 8'h00);
    check_output("pause_dv", dv_count[7:0], 8'd0);
    state = 1'b1;
    send_bits(8'h96, 4, 0);
    apply_stimulus(1'b1, 8'h96, 1'b1, 1'b0);

    // Asynchronous reset while the ACK bit is being driven
    pulse_en();
    send_bits(8'h5A, 7, 0);
    nack = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    allow_link = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    check_output("rst_ack_link_on", {7'd0, sdalink}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_link", {7'd0, sdalink}, 8'h00);
    check_output("async_nss", {7'd0, next_state_sig}, 8'h00);
    check_output("async_rd", rd_data, 8'h00);
    allow_link = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("async_dv_count", dv_count[7:0], 8'd0);
    check_output("async_dv", {7'd0, data_valid}, 8'h00);

    // scl_hs and scl_ls together in ACK_DRIVE: the falling edge wins
    pulse_en();
    send_bits(8'hC3, 7, 0);
    apply_stimulus(1'b0, 8'hC3, 1'b0, 1'b1);

    check_output("no_contention", violations[7:0], 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
